bus_master_port: RTL and testbench
==================================

BUS_MASTER_PORT -- requirements
Module: bus_master_port

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, slave-local address width.
REQ-002 SHALL have parameter DATA_W, default 8, data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, wait limit in cycles (used only with TIMEOUT_EN).
REQ-004 SHALL have port sys_clk  in  1  clock, all logic on rising edge.
REQ-005 SHALL have port sys_rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports cmd_valid in 1, cmd_ready out 1: user command handshake.
REQ-007 SHALL have ports cmd_rw in 1 (1=write), cmd_slave in 2, cmd_addr in ADDR_W, cmd_wdata in DATA_W: command fields.
REQ-008 SHALL have ports rsp_valid out 1 (one-cycle pulse), rsp_rdata out DATA_W, rsp_err out 1: completion.
REQ-009 SHALL have ports m_request out 1, m_slave_sel out 1 (serial slave id), m_grant in 1: arbiter side.
REQ-010 SHALL have ports bus_valid out 1, bus_tx out 1 (serial frame), bus_rx in 1, bus_rx_valid in 1, bus_ack in 1: slave data path via bus mux.

Function
REQ-011 SHALL implement states IDLE, SEL1, SEL0, WAIT_GRANT, TX, RX, ACK, DONE.
REQ-012 cmd_ready SHALL be 1 only in IDLE; a command SHALL be captured into internal registers on cmd_valid&cmd_ready (cycle 0), IDLE->SEL1.
REQ-013 SEL1 (cycle 1): m_request=1, m_slave_sel=cmd_slave[1]; SEL0 (cycle 2): m_request=1, m_slave_sel=cmd_slave[0]; m_slave_sel SHALL be 0 in all other states.
REQ-014 m_request SHALL stay 1 from SEL1 through RX/ACK and SHALL be 0 in DONE and IDLE.
REQ-015 WAIT_GRANT SHALL ignore m_grant for its first 2 cycles (stale-grant guard), then move to TX on the first cycle m_grant=1.
REQ-016 TX SHALL drive bus_valid=1 and shift out, one bit per cycle, cmd_rw then cmd_addr LSB-first, then cmd_wdata LSB-first when write: 1+ADDR_W bits (read) or 1+ADDR_W+DATA_W bits (write).
REQ-017 After the last TX bit: read -> RX, write -> ACK; bus_valid=0 and bus_tx=0 outside TX.
REQ-018 RX SHALL shift in bus_rx on each cycle with bus_rx_valid=1, LSB-first, and go to DONE after DATA_W valid bits; bus_rx_valid outside RX SHALL be ignored.
REQ-019 ACK SHALL go to DONE on the first cycle bus_ack=1; bus_ack outside ACK SHALL be ignored.
REQ-020 DONE SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; rsp_rdata SHALL hold the received word (0 for writes) until the next DONE.
REQ-021 If m_grant falls to 0 during TX, RX or ACK, the block SHALL go to DONE with rsp_err=1; otherwise rsp_err=0 in DONE.
REQ-022 rsp_err SHALL be valid only while rsp_valid=1 and 0 otherwise.

Reset
REQ-023 sys_rst=1 SHALL immediately force state IDLE, cmd_ready=1, and m_request, m_slave_sel, bus_valid, bus_tx, rsp_valid, rsp_err=0, rsp_rdata=0, all counters and shift registers to 0.
REQ-024 Reset mid-transaction SHALL abandon it without producing rsp_valid.

Configuration
REQ-025 With macro BUS_MASTER_PORT_TIMEOUT_EN defined, a cycle counter SHALL run in WAIT_GRANT, RX and ACK (cleared on state entry); reaching TIMEOUT_CYCLES SHALL go to DONE with rsp_err=1.
REQ-026 Without BUS_MASTER_PORT_TIMEOUT_EN, no timeout counter SHALL exist and those states SHALL wait indefinitely.

Verification
REQ-027 Write slave=2'b10, addr=0x0A5, wdata=0x3C, grant at cycle 5, bus_ack 2 cycles after TX -> m_slave_sel 1,0 on cycles 1,2; 21 TX bits starting 1,1,0,1; rsp_valid with rsp_err=0, rsp_rdata=0.
REQ-028 Read slave=2'b01, addr=0x001, slave returns 0xA5 LSB-first with gapped bus_rx_valid -> 13 TX bits, rsp_rdata=0xA5, rsp_err=0.
REQ-029 m_grant already 1 at command accept -> TX not before cycle 5 (guard honoured).
REQ-030 m_grant dropped mid-TX -> next cycle DONE, rsp_valid=1, rsp_err=1, m_request=0.
REQ-031 sys_rst pulsed during RX -> outputs at reset values within the same cycle, no rsp_valid; new command afterwards completes normally.
REQ-032 TIMEOUT_EN defined, TIMEOUT_CYCLES=10, grant never given -> rsp_err=1 after 10 WAIT_GRANT cycles; undefined -> still in WAIT_GRANT after 1000 cycles.

Source files
------------

// File: rtl/bus_master_port_if.sv
// Command, response, arbiter and serial-bus signals of bus_master_port.
// master: the port block. slave: the user, arbiter and bus mux around it.
interface bus_master_port_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_rw;
    logic [1:0]        cmd_slave;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              m_request;
    logic              m_slave_sel;
    logic              m_grant;
    logic              bus_valid;
    logic              bus_tx;
    logic              bus_rx;
    logic              bus_rx_valid;
    logic              bus_ack;

    modport master (
        input  cmd_valid, cmd_rw, cmd_slave, cmd_addr, cmd_wdata,
        input  m_grant, bus_rx, bus_rx_valid, bus_ack,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output m_request, m_slave_sel, bus_valid, bus_tx
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_slave, cmd_addr, cmd_wdata,
        output m_grant, bus_rx, bus_rx_valid, bus_ack,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  m_request, m_slave_sel, bus_valid, bus_tx
    );
endinterface

// File: rtl/bus_master_port.sv
// Serial bus master: slave select, arbitration, frame TX, data RX/ACK.
// Define BUS_MASTER_PORT_TIMEOUT_EN for a wait-state timeout.
module bus_master_port #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic              sys_clk,
    input logic              sys_rst,
    bus_master_port_if.master bus_if
);
    localparam int FR_W  = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(FR_W + 1);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] SEL1       = 3'd1;
    localparam logic [2:0] SEL0       = 3'd2;
    localparam logic [2:0] WAIT_GRANT = 3'd3;
    localparam logic [2:0] TX         = 3'd4;
    localparam logic [2:0] RX         = 3'd5;
    localparam logic [2:0] ACK        = 3'd6;
    localparam logic [2:0] DONE       = 3'd7;

    logic [2:0]        state_q, state_d;
    logic              rw_q, rw_d;
    logic [1:0]        slave_q, slave_d;
    logic [FR_W-1:0]   sh_q, sh_d;
    logic [CNT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [1:0]        gcnt_q, gcnt_d;
    logic              go_done;
    logic              fail;
    logic              tx_last;

`ifdef BUS_MASTER_PORT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`else
    if (TIMEOUT_CYCLES < 1) begin : g_tmo_chk
        $error("TIMEOUT_CYCLES must be positive");
    end
`endif

    assign tx_last = (bit_q == (rw_q ? CNT_W'(FR_W - 1) : CNT_W'(ADDR_W)));

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        slave_d = slave_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        gcnt_d  = gcnt_q;
        go_done = 1'b0;
        fail    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus_if.cmd_valid) begin
                    rw_d    = bus_if.cmd_rw;
                    slave_d = bus_if.cmd_slave;
                    sh_d    = {bus_if.cmd_wdata, bus_if.cmd_addr, bus_if.cmd_rw};
                    rx_d    = '0;
                    state_d = SEL1;
                end
            end
            SEL1: state_d = SEL0;
            SEL0: state_d = WAIT_GRANT;
            WAIT_GRANT: begin
                // A grant left over from an earlier owner is not trusted.
                if (gcnt_q != 2'd2) begin
                    gcnt_d = gcnt_q + 2'd1;
                end else if (bus_if.m_grant) begin
                    state_d = TX;
                end
            end
            TX: begin
                if (!bus_if.m_grant) begin
                    go_done = 1'b1;
                    fail    = 1'b1;
                end else begin
                    sh_d  = sh_q >> 1;
                    bit_d = bit_q + CNT_W'(1);
                    if (tx_last) state_d = rw_q ? ACK : RX;
                end
            end
            RX: begin
                if (!bus_if.m_grant) begin
                    go_done = 1'b1;
                    fail    = 1'b1;
                end else if (bus_if.bus_rx_valid) begin
                    rx_d  = {bus_if.bus_rx, rx_q[DATA_W-1:1]};
                    bit_d = bit_q + CNT_W'(1);
                    if (bit_q == CNT_W'(DATA_W - 1)) go_done = 1'b1;
                end
            end
            ACK: begin
                if (!bus_if.m_grant) begin
                    go_done = 1'b1;
                    fail    = 1'b1;
                end else if (bus_if.bus_ack) begin
                    go_done = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef BUS_MASTER_PORT_TIMEOUT_EN
        tmo_d = tmo_q;
        if ((state_q == WAIT_GRANT || state_q == RX || state_q == ACK)
            && !go_done && state_d == state_q) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                go_done = 1'b1;
                fail    = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
`endif

        if (go_done) begin
            state_d = DONE;
            err_d   = fail;
            rdata_d = rw_q ? '0 : rx_d;
        end

        // Per-state counters restart on every state change.
        if (state_d != state_q) begin
            bit_d  = '0;
            gcnt_d = '0;
`ifdef BUS_MASTER_PORT_TIMEOUT_EN
            tmo_d  = '0;
`endif
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            rw_q    <= 1'b0;
            slave_q <= '0;
            sh_q    <= '0;
            bit_q   <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            slave_q <= slave_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            gcnt_q  <= gcnt_d;
        end
    end

`ifdef BUS_MASTER_PORT_TIMEOUT_EN
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) tmo_q <= '0;
        else         tmo_q <= tmo_d;
    end
`endif

    assign bus_if.cmd_ready   = (state_q == IDLE);
    assign bus_if.m_request   = (state_q != IDLE) && (state_q != DONE);
    assign bus_if.m_slave_sel = (state_q == SEL1) ? slave_q[1] :
                                (state_q == SEL0) ? slave_q[0] : 1'b0;
    assign bus_if.bus_valid   = (state_q == TX);
    assign bus_if.bus_tx      = (state_q == TX) & sh_q[0];
    assign bus_if.rsp_valid   = (state_q == DONE);
    assign bus_if.rsp_err     = (state_q == DONE) & err_q;
    assign bus_if.rsp_rdata   = rdata_q;
endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port: write, read, guard, grant loss,
// reset during RX and the wait-for-grant limit.
module tb_bus_master_port;
    localparam int AW = 12;
    localparam int DW = 8;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    bus_master_port_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

    bus_master_port #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(10)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus_if (bif)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic accept(input logic rw, input logic [1:0] sl,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        bif.cmd_rw    = rw;
        bif.cmd_slave = sl;
        bif.cmd_addr  = a;
        bif.cmd_wdata = d;
        bif.cmd_valid = 1'b1;
        chk("accept_ready", bif.cmd_ready, 1);
        tick();
        bif.cmd_valid = 1'b0;
    endtask

    task automatic wait_bv(input string tag);
        int n = 0;
        while (!bif.bus_valid && n < 50) begin
            tick();
            n++;
        end
        chk(tag, bif.bus_valid, 1);
    endtask

    task automatic feed(input logic [DW-1:0] w, input bit gaps);
        for (int k = 0; k < DW; k++) begin
            if (gaps) begin
                bif.bus_rx_valid = 1'b0;
                bif.bus_rx       = ~w[k];
                tick();
            end
            bif.bus_rx_valid = 1'b1;
            bif.bus_rx       = w[k];
            tick();
        end
        bif.bus_rx_valid = 1'b0;
        bif.bus_rx       = 1'b0;
    endtask

    logic [31:0] got;
    logic        vld_all;
    logic        seen;
    logic [20:0] wframe;
    logic [12:0] rframe;

    initial begin
        bif.cmd_valid    = 1'b0;
        bif.cmd_rw       = 1'b0;
        bif.cmd_slave    = 2'b00;
        bif.cmd_addr     = '0;
        bif.cmd_wdata    = '0;
        bif.m_grant      = 1'b0;
        bif.bus_rx       = 1'b0;
        bif.bus_rx_valid = 1'b0;
        bif.bus_ack      = 1'b0;
        wframe = {8'h3C, 12'h0A5, 1'b1};
        rframe = {12'h001, 1'b0};

        #1;
        chk("rst_ready", bif.cmd_ready, 1);
        chk("rst_req",   bif.m_request, 0);
        chk("rst_sel",   bif.m_slave_sel, 0);
        chk("rst_bv",    bif.bus_valid, 0);
        chk("rst_tx",    bif.bus_tx, 0);
        chk("rst_rsp",   {bif.rsp_valid, bif.rsp_err}, 0);
        chk("rst_rdata", bif.rsp_rdata, 0);
        tick();
        tick();
        #2 sys_rst = 1'b0;
        tick();

        // Write to slave 2'b10, grant arrives in cycle 5.
        accept(1'b1, 2'b10, 12'h0A5, 8'h3C);
        chk("w_c1_req",   bif.m_request, 1);
        chk("w_c1_sel",   bif.m_slave_sel, 1);
        chk("w_c1_ready", bif.cmd_ready, 0);
        tick();
        chk("w_c2_req", bif.m_request, 1);
        chk("w_c2_sel", bif.m_slave_sel, 0);
        tick();
        chk("w_c3_sel", bif.m_slave_sel, 0);
        tick();
        chk("w_c4_bv", bif.bus_valid, 0);
        bif.m_grant = 1'b1;
        tick();
        chk("w_c5_bv", bif.bus_valid, 0);
        tick();
        got = '0;
        vld_all = 1'b1;
        for (int i = 0; i < 21; i++) begin
            got[i] = bif.bus_tx;
            vld_all &= bif.bus_valid;
            tick();
        end
        chk("w_first4", got[3:0], 4'b1011);
        chk("w_frame",  got, {11'd0, wframe});
        chk("w_tx_bv",  vld_all, 1);
        chk("w_ack_bv", {bif.bus_valid, bif.bus_tx}, 0);
        tick();
        tick();
        chk("w_ack_wait", {bif.rsp_valid, bif.m_request}, 2'b01);
        bif.bus_ack = 1'b1;
        tick();
        bif.bus_ack = 1'b0;
        chk("w_done",  {bif.rsp_valid, bif.rsp_err}, 2'b10);
        chk("w_rdata", bif.rsp_rdata, 0);
        chk("w_d_req", bif.m_request, 0);
        tick();
        chk("w_after", {bif.rsp_valid, bif.rsp_err, bif.cmd_ready}, 3'b001);

        // Read from slave 2'b01 with grant already high at accept.
        accept(1'b0, 2'b01, 12'h001, 8'h00);
        chk("r_c1_sel", bif.m_slave_sel, 0);
        tick();
        chk("r_c2_sel", bif.m_slave_sel, 1);
        tick();
        tick();
        tick();
        chk("r_guard_c5", bif.bus_valid, 0);
        tick();
        chk("r_tx_c6", bif.bus_valid, 1);
        got = '0;
        vld_all = 1'b1;
        for (int i = 0; i < 13; i++) begin
            got[i] = bif.bus_tx;
            vld_all &= bif.bus_valid;
            tick();
        end
        chk("r_frame", got, {19'd0, rframe});
        chk("r_tx_bv", vld_all, 1);
        chk("r_rx_bv", bif.bus_valid, 0);
        feed(8'hA5, 1'b1);
        chk("r_done",  {bif.rsp_valid, bif.rsp_err}, 2'b10);
        chk("r_rdata", bif.rsp_rdata, 8'hA5);
        tick();
        chk("r_after", bif.rsp_valid, 0);
        chk("r_hold",  bif.rsp_rdata, 8'hA5);

        // Grant withdrawn in the fourth TX cycle.
        accept(1'b1, 2'b11, 12'hFFF, 8'hFF);
        wait_bv("g_tx_start");
        tick();
        tick();
        tick();
        bif.m_grant = 1'b0;
        tick();
        chk("g_done", {bif.rsp_valid, bif.rsp_err}, 2'b11);
        chk("g_req",  bif.m_request, 0);
        chk("g_bv",   bif.bus_valid, 0);
        tick();
        chk("g_after", {bif.rsp_valid, bif.rsp_err}, 0);
        bif.m_grant = 1'b1;

        // Reset during RX of a read.
        accept(1'b0, 2'b00, 12'h123, 8'h00);
        wait_bv("x_tx_start");
        repeat (13) tick();
        chk("x_in_rx", {bif.m_request, bif.bus_valid}, 2'b10);
        bif.bus_rx_valid = 1'b1;
        bif.bus_rx       = 1'b1;
        repeat (3) tick();
        #2 sys_rst = 1'b1;
        #1;
        chk("x_rst_ready", bif.cmd_ready, 1);
        chk("x_rst_req",   bif.m_request, 0);
        chk("x_rst_rsp",   {bif.rsp_valid, bif.rsp_err}, 0);
        chk("x_rst_rdata", bif.rsp_rdata, 0);
        tick();
        chk("x_rst_hold", {bif.rsp_valid, bif.m_request}, 0);
        #2 sys_rst = 1'b0;
        bif.bus_rx_valid = 1'b0;
        bif.bus_rx       = 1'b0;
        tick();
        accept(1'b0, 2'b01, 12'h0F0, 8'h00);
        wait_bv("x2_tx_start");
        repeat (13) tick();
        feed(8'h5A, 1'b0);
        chk("x2_done",  {bif.rsp_valid, bif.rsp_err}, 2'b10);
        chk("x2_rdata", bif.rsp_rdata, 8'h5A);
        tick();

        // No grant at all.
        bif.m_grant = 1'b0;
        accept(1'b0, 2'b00, 12'h000, 8'h00);
`ifdef BUS_MASTER_PORT_TIMEOUT_EN
        repeat (11) tick();
        chk("t_c12", bif.rsp_valid, 0);
        tick();
        chk("t_timeout", {bif.rsp_valid, bif.rsp_err}, 2'b11);
        tick();
`else
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            seen |= bif.rsp_valid;
            tick();
        end
        chk("t_no_rsp", seen, 0);
        chk("t_waiting", {bif.m_request, bif.cmd_ready}, 2'b10);
        #2 sys_rst = 1'b1;
        tick();
        #2 sys_rst = 1'b0;
        tick();
`endif
        chk("t_idle", {bif.cmd_ready, bif.m_request}, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
